// File: rtl/pulse_seq_pkg.sv
// ----------------------------------------------------------------------------
// pulse_seq_pkg
// Shared types and helpers for the multi-channel pulse sequencer.
//   state_t      : sequencer FSM state (IDLE / RUN)
//   DEF_*        : default parameter values used by pulse_seq_multi
//   chan_field() : extracts channel idx (field width fw) from a packed
//                  per-channel configuration vector
// ----------------------------------------------------------------------------
package pulse_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_NCH    = 4;
   localparam int DEF_CW     = 32;
   localparam int DEF_TW     = 16;
   localparam int DEF_RW     = 8;
   localparam int DEF_SYNC_W = 8;

   // Widest packed vector chan_field() accepts: 8 channels of up to 64 bits.
   localparam int MAX_NCH = 8;
   localparam int MAX_FW  = 64;
   localparam int MAX_VW  = MAX_NCH * MAX_FW;

   // Callers zero-extend their vector to MAX_VW and truncate the result to
   // their own field width; the mask keeps neighbouring fields out.
   function automatic logic [MAX_VW-1:0] chan_field(
      input logic [MAX_VW-1:0] vec,
      input int unsigned       idx,
      input int unsigned       fw
   );
      return (vec >> (idx * fw)) & ~({MAX_VW{1'b1}} << fw);
   endfunction

endpackage

// File: rtl/pulse_seq_chan.sv
// ----------------------------------------------------------------------------
// pulse_seq_chan
// One pulse channel: emits up to rep equal pulses of length width, spaced
// space clocks start-to-start, beginning at cnt == start. Edge positions are
// tracked incrementally; the channel state re-initialises at cnt == 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : sequencer is in RUN
//   block      : live inhibit of the output (state keeps advancing)
//   cnt        : period counter of the current cycle
//   start      : first pulse start
//   width      : pulse width (0 = silent)
//   space      : start-to-start spacing
//   rep        : pulse count (0 = silent)
//   pulse      : registered channel output, one clock behind cnt
// ----------------------------------------------------------------------------
module pulse_seq_chan
   import pulse_seq_pkg::*;
#(
   parameter int CW = DEF_CW,
   parameter int TW = DEF_TW,
   parameter int RW = DEF_RW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic          block,
   input  logic [CW-1:0] cnt,
   input  logic [TW-1:0] start,
   input  logic [TW-1:0] width,
   input  logic [TW-1:0] space,
   input  logic [RW-1:0] rep,
   output logic          pulse
);

   // One extra bit so start + k*space + width never wraps.
   logic [CW:0]   next_rise, fall;
   logic [CW:0]   rise_e, fall_e, cnt_x;
   logic [RW-1:0] remain, remain_e;
   logic          period_start, trig, high;

   always_comb begin
      cnt_x        = {1'b0, cnt};
      period_start = (cnt == '0);
      // At cnt == 0 use the fresh per-period values instead of the registers,
      // so a pulse still high at wrap is dropped and start == 0 fires at once.
      rise_e       = period_start ? (CW+1)'(start) : next_rise;
      fall_e       = period_start ? '0 : fall;
      remain_e     = period_start ? rep : remain;
      // A rise falls on an exact cnt match; since cnt < per, rises at or past
      // per are never reached. space == 0 never matches again -> single pulse.
      trig         = run && (width != '0) && (remain_e != '0) && (cnt_x == rise_e);
      // Later pulses always fall later, so the latest fall covers overlapping
      // (retriggered) pulses as one continuous high.
      high         = run && (width != '0) && (trig || (cnt_x < fall_e));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_rise <= '0;
         fall      <= '0;
         remain    <= '0;
         pulse     <= 1'b0;
      end else begin
         if (trig) begin
            next_rise <= rise_e + (CW+1)'(space);
            fall      <= cnt_x + (CW+1)'(width);
            remain    <= remain_e - RW'(1);
         end else begin
            next_rise <= rise_e;
            fall      <= fall_e;
            remain    <= remain_e;
         end
         pulse <= high && !block;
      end
   end

endmodule

// File: rtl/pulse_seq_multi.sv
// ----------------------------------------------------------------------------
// pulse_seq_multi
// Multi-channel pulse sequencer. Holds a pending and an active configuration
// bank, the IDLE/RUN FSM, the period counter and SYNC generation; each channel
// is a pulse_seq_chan instance. A new configuration is applied only at a
// period wrap (or immediately when idle), so outputs never glitch mid-period.
// Ports:
//   clk, rst_n  : sequencer clock, asynchronous active-low reset
//   cfg_valid   : one-cycle strobe capturing cfg_* into the pending bank
//   cfg_per     : period in clocks
//   cfg_start   : per-channel first pulse start, channel i at [i*TW +: TW]
//   cfg_width   : per-channel pulse width
//   cfg_space   : per-channel start-to-start spacing
//   cfg_rep     : per-channel pulse count, channel i at [i*RW +: RW]
//   block       : live inhibit forcing all pulse_out low
//   cfg_ack     : one-cycle pulse when the pending bank became active
//   sync_out    : period marker, high for min(SYNC_W, per) clocks
//   pulse_out   : channel switch drives
//   running     : FSM is in RUN (active period >= 2)
// ----------------------------------------------------------------------------
module pulse_seq_multi
   import pulse_seq_pkg::*;
#(
   parameter int NCH    = DEF_NCH,
   parameter int CW     = DEF_CW,
   parameter int TW     = DEF_TW,
   parameter int RW     = DEF_RW,
   parameter int SYNC_W = DEF_SYNC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   input  logic [CW-1:0]     cfg_per,
   input  logic [NCH*TW-1:0] cfg_start,
   input  logic [NCH*TW-1:0] cfg_width,
   input  logic [NCH*TW-1:0] cfg_space,
   input  logic [NCH*RW-1:0] cfg_rep,
   input  logic              block,
   output logic              cfg_ack,
   output logic              sync_out,
   output logic [NCH-1:0]    pulse_out,
   output logic              running
);

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [CW-1:0]     sync_lim;
   logic              wrap, copy, sync_hit;

   logic [CW-1:0]     act_per,   pnd_per;
   logic [NCH*TW-1:0] act_start, pnd_start;
   logic [NCH*TW-1:0] act_width, pnd_width;
   logic [NCH*TW-1:0] act_space, pnd_space;
   logic [NCH*RW-1:0] act_rep,   pnd_rep;
   logic              pnd_flag;

   // ---------------------------------------------------------------- FSM / counter
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      wrap      = (cnt == act_per - CW'(1));
      copy      = pnd_flag && ((state == IDLE) || wrap);

      case (state)
         IDLE:    cnt_nxt = '0;
         RUN:     cnt_nxt = wrap ? '0 : cnt + CW'(1);
         default: cnt_nxt = '0;
      endcase

      // Applying the pending bank always restarts the period; a period below
      // 2 cannot run and parks the sequencer.
      if (copy) begin
         cnt_nxt   = '0;
         state_nxt = (pnd_per >= CW'(2)) ? RUN : IDLE;
      end

      sync_lim = (act_per < CW'(SYNC_W)) ? act_per : CW'(SYNC_W);
      sync_hit = (state == RUN) && (cnt < sync_lim);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cfg_ack   <= 1'b0;
         sync_out  <= 1'b0;
         pnd_flag  <= 1'b0;
         // NOTE: the configuration banks are reset too, because an all-zero
         // active bank is what guarantees silent outputs after reset.
         act_per   <= '0;
         act_start <= '0;
         act_width <= '0;
         act_space <= '0;
         act_rep   <= '0;
         pnd_per   <= '0;
         pnd_start <= '0;
         pnd_width <= '0;
         pnd_space <= '0;
         pnd_rep   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         cfg_ack  <= copy;
         sync_out <= sync_hit;
         // A strobe coinciding with a copy stays pending for the next wrap.
         pnd_flag <= cfg_valid | (pnd_flag & ~copy);
         if (copy) begin
            act_per   <= pnd_per;
            act_start <= pnd_start;
            act_width <= pnd_width;
            act_space <= pnd_space;
            act_rep   <= pnd_rep;
         end
         if (cfg_valid) begin
            pnd_per   <= cfg_per;
            pnd_start <= cfg_start;
            pnd_width <= cfg_width;
            pnd_space <= cfg_space;
            pnd_rep   <= cfg_rep;
         end
      end
   end

   assign running = (state == RUN);

   // ---------------------------------------------------------------- channels
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic [TW-1:0] start_i, width_i, space_i;
      logic [RW-1:0] rep_i;

      assign start_i = TW'(chan_field(MAX_VW'(act_start), i, TW));
      assign width_i = TW'(chan_field(MAX_VW'(act_width), i, TW));
      assign space_i = TW'(chan_field(MAX_VW'(act_space), i, TW));
      assign rep_i   = RW'(chan_field(MAX_VW'(act_rep),   i, RW));

      pulse_seq_chan #(
         .CW (CW),
         .TW (TW),
         .RW (RW)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .run   (state == RUN),
         .block (block),
         .cnt   (cnt),
         .start (start_i),
         .width (width_i),
         .space (space_i),
         .rep   (rep_i),
         .pulse (pulse_out[i])
      );
   end

endmodule

// File: tb/tb_pulse_seq_multi.sv
// ----------------------------------------------------------------------------
// tb_pulse_seq_multi
// Self-checking bench for pulse_seq_multi. A behavioural model tracks the
// period counter and configuration banks; channel outputs are derived from
// the pulse-train definition (pulse k covers [start+k*space, +width)).
// ----------------------------------------------------------------------------
module tb_pulse_seq_multi;

   localparam int NCH    = 4;
   localparam int CW     = 32;
   localparam int TW     = 16;
   localparam int RW     = 8;
   localparam int SYNC_W = 8;

   typedef struct {
      int per;
      int start [NCH];
      int width [NCH];
      int space [NCH];
      int rep   [NCH];
   } cfg_t;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              cfg_valid = 1'b0;
   logic [CW-1:0]     cfg_per   = '0;
   logic [NCH*TW-1:0] cfg_start = '0;
   logic [NCH*TW-1:0] cfg_width = '0;
   logic [NCH*TW-1:0] cfg_space = '0;
   logic [NCH*RW-1:0] cfg_rep   = '0;
   logic              block     = 1'b0;
   logic              cfg_ack;
   logic              sync_out;
   logic [NCH-1:0]    pulse_out;
   logic              running;

   always #5 clk = ~clk;

   pulse_seq_multi #(
      .NCH    (NCH),
      .CW     (CW),
      .TW     (TW),
      .RW     (RW),
      .SYNC_W (SYNC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_per   (cfg_per),
      .cfg_start (cfg_start),
      .cfg_width (cfg_width),
      .cfg_space (cfg_space),
      .cfg_rep   (cfg_rep),
      .block     (block),
      .cfg_ack   (cfg_ack),
      .sync_out  (sync_out),
      .pulse_out (pulse_out),
      .running   (running)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "init";

   // model state
   cfg_t m_act, m_pnd, cur_in;
   bit   m_pend, m_run;
   int   m_cnt;
   int   hi_cnt [NCH];
   int   sync_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   function automatic cfg_t zero_cfg();
      cfg_t c;
      c.per = 0;
      for (int i = 0; i < NCH; i++) begin
         c.start[i] = 0;
         c.width[i] = 0;
         c.space[i] = 0;
         c.rep[i]   = 0;
      end
      return c;
   endfunction

   // Is channel ch high at counter value cnt under configuration c?
   function automatic bit chan_high(cfg_t c, int ch, int cnt);
      int n, s;
      if (c.rep[ch] == 0 || c.width[ch] == 0) return 1'b0;
      n = (c.space[ch] == 0) ? 1 : c.rep[ch];
      for (int k = 0; k < n; k++) begin
         s = c.start[ch] + k * c.space[ch];
         if (s >= c.per) break;
         if (cnt >= s && cnt < s + c.width[ch]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_reset();
      m_act  = zero_cfg();
      m_pnd  = zero_cfg();
      m_pend = 1'b0;
      m_run  = 1'b0;
      m_cnt  = 0;
   endfunction

   function automatic void clear_counts();
      for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
      sync_cnt = 0;
   endfunction

   task automatic drive(input cfg_t c);
      cur_in  = c;
      cfg_per = CW'(c.per);
      for (int i = 0; i < NCH; i++) begin
         cfg_start[i*TW +: TW] = TW'(c.start[i]);
         cfg_width[i*TW +: TW] = TW'(c.width[i]);
         cfg_space[i*TW +: TW] = TW'(c.space[i]);
         cfg_rep[i*RW +: RW]   = RW'(c.rep[i]);
      end
   endtask

   // One clock: predict from pre-edge state, advance the model, compare.
   task automatic tick();
      bit             copy, exp_sync;
      logic [NCH-1:0] exp_pulse;
      int             lim;
      copy     = m_pend && (!m_run || m_cnt == m_act.per - 1);
      lim      = (m_act.per < SYNC_W) ? m_act.per : SYNC_W;
      exp_sync = m_run && (m_cnt < lim);
      for (int i = 0; i < NCH; i++)
         exp_pulse[i] = m_run && !block && chan_high(m_act, i, m_cnt);
      @(posedge clk);
      if (copy) begin
         m_act = m_pnd;
         m_run = (m_act.per >= 2);
         m_cnt = 0;
      end else if (m_run) begin
         m_cnt = (m_cnt == m_act.per - 1) ? 0 : m_cnt + 1;
      end
      if (cfg_valid) begin
         m_pnd  = cur_in;
         m_pend = 1'b1;
      end else if (copy) begin
         m_pend = 1'b0;
      end
      #1;
      check("cfg_ack",   64'(cfg_ack),   64'(copy));
      check("sync_out",  64'(sync_out),  64'(exp_sync));
      check("pulse_out", 64'(pulse_out), 64'(exp_pulse));
      check("running",   64'(running),   64'(m_run));
      for (int i = 0; i < NCH; i++) if (pulse_out[i]) hi_cnt[i]++;
      if (sync_out) sync_cnt++;
   endtask

   task automatic apply(input cfg_t c);
      drive(c);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic run_to(input int target);
      int guard = 0;
      while (m_cnt != target && guard < 2000) begin
         tick();
         guard++;
      end
      if (m_cnt != target) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s/run_to timeout observed=%0d expected=%0d", phase, m_cnt, target);
      end
   endtask

   task automatic run_rand(input int n);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 9) == 0) block = ~block;
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_t c1, c2, c3a, c3b, c4, c5, cr;

      // ---------------------------------------------------------- reset
      phase = "reset";
      model_reset();
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      check("rst_pulse",   64'(pulse_out), 64'(0));
      check("rst_sync",    64'(sync_out),  64'(0));
      check("rst_ack",     64'(cfg_ack),   64'(0));
      check("rst_running", 64'(running),   64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_n(5);

      // ---------------------------------------------------------- 1: single pulse
      phase = "s1";
      c1 = zero_cfg();
      c1.per = 100; c1.start[0] = 10; c1.width[0] = 5; c1.rep[0] = 1;
      apply(c1);
      tick();
      check("ack_after_cfg", 64'(cfg_ack), 64'(1));
      run_to(0);
      clear_counts();
      run_n(100);
      check("ch0_high_clocks", 64'(hi_cnt[0]), 64'(5));
      check("sync_high_clocks", 64'(sync_cnt), 64'(8));

      // ---------------------------------------------------------- 2: pulse train
      phase = "s2";
      c2 = c1;
      c2.start[1] = 20; c2.width[1] = 4; c2.space[1] = 10; c2.rep[1] = 3;
      apply(c2);
      run_to(99);
      tick();
      run_to(0);
      clear_counts();
      run_to(51);
      check("ch1_low_at_50", 64'(pulse_out[1]), 64'(0));
      run_to(0);
      check("ch1_high_clocks", 64'(hi_cnt[1]), 64'(12));
      check("ch0_high_clocks", 64'(hi_cnt[0]), 64'(5));

      // ---------------------------------------------------------- 5: block
      phase = "s5";
      clear_counts();
      run_to(28);
      block = 1'b1;
      run_to(37);
      block = 1'b0;
      run_to(41);
      check("ch1_p3_on_time", 64'(pulse_out[1]), 64'(1));
      run_to(0);
      check("ch1_high_clocks", 64'(hi_cnt[1]), 64'(8));
      check("sync_high_clocks", 64'(sync_cnt), 64'(8));

      // ---------------------------------------------------------- 3: mid-period update
      phase = "s3";
      c3a = c2; c3a.width[0] = 6;
      c3b = c2; c3b.width[0] = 7;
      run_to(50);
      apply(c3a);
      run_n(5);
      apply(c3b);
      run_to(99);
      check("no_ack_before_wrap", 64'(cfg_ack), 64'(0));
      tick();
      check("ack_after_wrap", 64'(cfg_ack), 64'(1));
      clear_counts();
      run_n(100);
      check("ch0_width7_clocks", 64'(hi_cnt[0]), 64'(7));
      check("ch1_high_clocks",   64'(hi_cnt[1]), 64'(12));

      // ---------------------------------------------------------- 4: boundaries
      phase = "s4";
      c4 = zero_cfg();
      c4.per = 50;
      c4.start[0] = 0;  c4.width[0] = 5; c4.space[0] = 3; c4.rep[0] = 3;
      c4.start[1] = 5;  c4.width[1] = 5; c4.rep[1] = 0;
      c4.start[2] = 48; c4.width[2] = 5; c4.rep[2] = 1;
      c4.start[3] = 60; c4.width[3] = 5; c4.rep[3] = 1;
      apply(c4);
      run_to(99);
      tick();
      clear_counts();
      run_n(50);
      check("retrig_high_clocks", 64'(hi_cnt[0]), 64'(11));
      check("rep0_high_clocks",   64'(hi_cnt[1]), 64'(0));
      check("wrap_cut_clocks",    64'(hi_cnt[2]), 64'(2));
      check("beyond_per_clocks",  64'(hi_cnt[3]), 64'(0));
      c5 = c4;
      c5.per = 1;
      apply(c5);
      run_n(60);
      check("per1_running", 64'(running),   64'(0));
      check("per1_pulse",   64'(pulse_out), 64'(0));
      check("per1_sync",    64'(sync_out),  64'(0));

      // ---------------------------------------------------------- 6: reset mid-pulse
      phase = "s6";
      apply(c1);
      run_to(12);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_pulse",   64'(pulse_out), 64'(0));
      check("async_sync",    64'(sync_out),  64'(0));
      check("async_running", 64'(running),   64'(0));
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_n(20);
      check("idle_after_reset", 64'(running), 64'(0));

      // ---------------------------------------------------------- random
      phase = "rand";
      for (int it = 0; it < 40; it++) begin
         cr = zero_cfg();
         cr.per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1))
                                              : int'($urandom_range(2, 60));
         for (int i = 0; i < NCH; i++) begin
            cr.start[i] = $urandom_range(0, 70);
            cr.width[i] = $urandom_range(0, 12);
            cr.space[i] = $urandom_range(0, 15);
            cr.rep[i]   = $urandom_range(0, 5);
         end
         apply(cr);
         run_rand($urandom_range(30, 150));
      end
      block = 1'b0;
      run_n(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
